keypad_scanner: RTL and testbench

Matrix-keypad input scanner for the stopwatch board: the input-side counterpart of the multiplexed display driver. It drives the four rows of a 4×4 keypad one at a time and samples the four columns. Presses are debounced and reported as a 4-bit key code with a one-cycle valid strobe, which the control FSM uses for start, stop, lap and clear. It runs on the same 10 kHz scan clock as the display driver (1 cycle = 0.1 ms).

---
 rtl/keypad_scanner_pkg.sv | 47 ++++
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/keypad_scanner_sync_2ff.sv | 32 +++
 rtl/keypad_scanner.sv | 140 ++++++++++++++
 tb/tb_keypad_scanner.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
//   Shared definitions for the keypad scanner: FSM state encodings,
//   stopwatch key-code constants and small decode helpers used by the
//   scanner and its bench.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    // Stopwatch control keys (row 0 of the pad)
    localparam logic [3:0] KEY_START = 4'h0;
    localparam logic [3:0] KEY_STOP  = 4'h1;
    localparam logic [3:0] KEY_LAP   = 4'h2;
    localparam logic [3:0] KEY_CLEAR = 4'h3;

    // Column lines are active-low; all-high means nothing pressed
    localparam logic [3:0] COL_IDLE = 4'hF;

    // True only when exactly one column line is low. Zero or several low
    // lines (ghosting / multi-key) are treated as no press.
    function automatic logic single_low(input logic [3:0] c);
        case (c)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Position of the single low bit (bit 0 -> column 0)
    function automatic logic [1:0] col_index(input logic [3:0] c);
        case (c)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // One-hot-low row drive for a row index
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Keypad matrix and key-event bundle.
//   key_col   : column lines from the pad (active-low, async to the clock)
//   key_row   : row drive to the pad (active-low, one-hot-low)
//   key_code  : last accepted key, row*4 + col
//   key_valid : one-cycle strobe when key_code updates
//   key_held  : high while the accepted key stays pressed
//   master = scanner side, slave = pad/consumer side.
interface keypad_scanner_if;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  key_col,
        output key_row, key_code, key_valid, key_held
    );

    modport slave (
        output key_col,
        input  key_row, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for asynchronous board inputs.
//   clk_i  : destination clock
//   rst_ni : async active-low reset, both flops load RESET_VAL
//   d_i    : asynchronous input
//   q_o    : synchronized output (2 cycles of latency)
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   4x4 matrix keypad scanner for the stopwatch board. Drives one row low
//   at a time, samples the synchronized columns at the end of each row
//   dwell, debounces presses and releases, and reports the accepted key
//   as row*4+col with a one-cycle valid strobe.
//   clk_10KHz : scan clock (rising edge)
//   rst_n     : async active-low reset
//   kp        : keypad_scanner_if.master (key_col in; key_row, key_code,
//               key_valid, key_held out)
//   ROW_DWELL    : cycles per row before sampling (>= 3, so the two-flop
//                  synchronizer has settled on the driven row)
//   DEBOUNCE_CNT : stable cycles required for press and for release (>= 2)
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int ROW_DWELL    = 10,
    parameter int DEBOUNCE_CNT = 200
) (
    input  logic             clk_10KHz,
    input  logic             rst_n,
    keypad_scanner_if.master kp
);

    localparam int CNT_MAX = (ROW_DWELL > DEBOUNCE_CNT) ? ROW_DWELL : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DWELL_LAST = CW'(ROW_DWELL - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [3:0]    col_s;

    kp_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    row_idx_q;
    logic [3:0]    key_row_q;
    logic [3:0]    pat_q;        // column pattern latched when the press was first seen
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;

    logic [1:0]    row_idx_d;    // next row in the rotation

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (COL_IDLE)
    ) u_col_sync (
        .clk_i  (clk_10KHz),
        .rst_ni (rst_n),
        .d_i    (kp.key_col),
        .q_o    (col_s)
    );

    assign row_idx_d = row_idx_q + 2'd1;

    always_ff @(posedge clk_10KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            cnt_q       <= '0;
            row_idx_q   <= 2'd0;
            key_row_q   <= 4'b1110;
            pat_q       <= COL_IDLE;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;

            case (state_q)
                ST_SCAN: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_q <= '0;
                        if (single_low(col_s)) begin
                            // Keep this row driven while the press settles
                            pat_q   <= col_s;
                            state_q <= ST_DEBOUNCE;
                        end else begin
                            row_idx_q <= row_idx_d;
                            key_row_q <= row_drive(row_idx_d);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (col_s != pat_q) begin
                        // Bounce or change of key: abandon and resume the scan
                        state_q   <= ST_SCAN;
                        cnt_q     <= '0;
                        row_idx_q <= row_idx_d;
                        key_row_q <= row_drive(row_idx_d);
                    end else if (cnt_q == DB_LAST) begin
                        key_code_q  <= {row_idx_q, col_index(pat_q)};
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        state_q     <= ST_HOLD;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_HOLD: begin
                    // Row stays frozen; second keys or ghost patterns are ignored
                    if (col_s == COL_IDLE) begin
                        state_q <= ST_RELEASE;
                        cnt_q   <= '0;
                    end
                end

                ST_RELEASE: begin
                    if (col_s != COL_IDLE) begin
                        // Release bounce restarts the stability window
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        key_held_q <= 1'b0;
                        state_q    <= ST_SCAN;
                        cnt_q      <= '0;
                        row_idx_q  <= row_idx_d;
                        key_row_q  <= row_drive(row_idx_d);
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= ST_SCAN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign kp.key_row   = key_row_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    localparam int RD = 4;
    localparam int DC = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(
        .ROW_DWELL    (RD),
        .DEBOUNCE_CNT (DC)
    ) dut (
        .clk_10KHz (clk),
        .rst_n     (rst_n),
        .kp        (kp)
    );

    // Physical pad model: bit r*4+c set = key at row r, col c pressed.
    // A column reads low only when a pressed key sits on a driven row.
    logic [15:0] keys = '0;

    function automatic logic [3:0] matrix_cols(input logic [15:0] k, input logic [3:0] rows);
        logic [3:0] cols;
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (k[r*4+c] && !rows[r]) cols[c] = 1'b0;
        return cols;
    endfunction

    assign kp.key_col = matrix_cols(keys, kp.key_row);

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected key codes pushed with stimulus, popped on key_valid
    logic [3:0] exp_q[$];
    logic [3:0] prev_code  = 4'h0;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        check("row_one_hot_low", single_low(kp.key_row), 1);
        if (!rst_n) begin
            prev_code  <= 4'h0;
            prev_valid <= 1'b0;
        end else begin
            if (kp.key_valid) begin
                check("valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("key_code", kp.key_code, exp_q.pop_front());
                check("valid_single_cycle", prev_valid, 0);
            end
            if (kp.key_code !== prev_code) check("code_changes_with_valid", kp.key_valid, 1);
            prev_code  <= kp.key_code;
            prev_valid <= kp.key_valid;
        end
    end

    // Wait for key_row to switch onto row pattern r (bounded)
    task automatic wait_row(input logic [3:0] r, output bit ok);
        logic [3:0] last;
        ok   = 1'b0;
        last = kp.key_row;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (kp.key_row === r && last !== r) begin
                ok = 1'b1;
                break;
            end
            last = kp.key_row;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"},   kp.key_row,   4'b1110);
        check({tag, "_code"},  kp.key_code,  4'h0);
        check({tag, "_valid"}, kp.key_valid, 1'b0);
        check({tag, "_held"},  kp.key_held,  1'b0);
    endtask

    task automatic check_scan_restart(input string tag);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check(tag, kp.key_row, row_drive(2'(k / RD)));
        end
    endtask

    initial begin
        bit ok;
        int n;
        logic [3:0] r0;

        // Reset state
        keys  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle scan: row changes every RD cycles and wraps
        for (int k = 1; k <= 4*RD + 1; k++) begin
            @(negedge clk);
            check("idle_scan_row", kp.key_row, row_drive(2'((k / RD) % 4)));
        end

        // Clean press row 2 col 1 -> code 9
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        repeat (40) @(negedge clk);
        check("press9_held", kp.key_held, 1'b1);
        check("press9_code", kp.key_code, 4'h9);
        keys = '0;
        n = 0;
        while (kp.key_held && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("release_latency_lo", n >= DC + 2, 1);
        check("release_latency_hi", n <= DC + 3, 1);
        repeat (5) @(negedge clk);

        // Bouncing press row 1 col 3 -> code 7, only after it settles
        for (int i = 0; i < 5; i++) begin
            keys[7] = ~keys[7];
            @(negedge clk);
        end
        keys[7] = 1'b1;
        exp_q.push_back(4'h7);
        repeat (40) @(negedge clk);
        check("press7_held", kp.key_held, 1'b1);
        check("press7_code", kp.key_code, 4'h7);
        keys = '0;
        n = 0;
        while (kp.key_held && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("press7_released", kp.key_held, 1'b0);
        repeat (3) @(negedge clk);

        // Ghost: col 0 and col 2 on row 0 together -> rejected, scan keeps rotating
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        repeat (40) @(negedge clk);
        r0 = kp.key_row;
        repeat (RD) @(negedge clk);
        check("ghost_scan_rotates", kp.key_row !== r0, 1);
        check("ghost_code_kept", kp.key_code, 4'h7);
        check("ghost_not_held", kp.key_held, 1'b0);
        keys = '0;
        repeat (5) @(negedge clk);

        // Short press on row 1 (fewer than DC stable cycles) -> no valid
        wait_row(4'b1101, ok);
        check("short_row_found", ok, 1);
        keys[5] = 1'b1;
        repeat (7) @(negedge clk);
        keys = '0;
        repeat (30) @(negedge clk);
        check("short_code_kept", kp.key_code, 4'h7);
        check("short_not_held", kp.key_held, 1'b0);

        // Reset while debouncing row 3 col 1
        wait_row(4'b0111, ok);
        check("dbrst_row_found", ok, 1);
        keys[13] = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_in_debounce");
        keys = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_scan_restart("dbrst_restart_row");

        // Reset while holding row 3 col 2 -> code E
        keys[14] = 1'b1;
        exp_q.push_back(4'hE);
        n = 0;
        while (!kp.key_held && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("holdrst_held", kp.key_held, 1'b1);
        check("holdrst_code", kp.key_code, 4'hE);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_in_hold");
        keys = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_scan_restart("holdrst_restart_row");

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
